// File: rtl/icache_refill_if.sv
// icache_refill_if
// Bundles the miss handshake, memory fill bus and array write ports of the
// instruction-cache refill controller.
//   master : the refill controller (consumes miss/flush/fill, drives arrays)
//   slave  : the surrounding pipeline, memory and cache arrays
// Signals:
//   i_miss_valid/tag/set/status  miss request and the set's status word
//   i_flush                      invalidate-all request
//   i_mem_data/i_mem_data_valid  fill beats from memory
//   o_miss_ready, o_stall        pipeline handshake and halt
//   o_mem_addr/o_mem_req_valid   line request to memory
//   o_da_w_*, o_ta_w_*, o_sa_w_* data, tag and status array write ports
//   o_refill_done/o_refill_way   completion pulse and chosen way
interface icache_refill_if #(
    parameter int TAG_BITS_WIDTH    = 8,
    parameter int SET_BITS_WIDTH    = 4,
    parameter int NUM_BLOCKS        = 4,
    parameter int WORD_WIDTH        = 20,
    parameter int MEM_IF_DATA_WIDTH = 128,
    parameter int MEM_IF_ADDR_WIDTH = 16
);
    localparam int WAY_W    = $clog2(NUM_BLOCKS);
    localparam int STATUS_W = 2 * NUM_BLOCKS;
    localparam int LINE_W   = 4 * WORD_WIDTH;

    logic                                 i_miss_valid;
    logic [TAG_BITS_WIDTH-1:0]            i_miss_tag;
    logic [SET_BITS_WIDTH-1:0]            i_miss_set;
    logic [STATUS_W-1:0]                  i_miss_status;
    logic                                 i_flush;
    logic [MEM_IF_DATA_WIDTH-1:0]         i_mem_data;
    logic                                 i_mem_data_valid;

    logic                                 o_miss_ready;
    logic                                 o_stall;
    logic [MEM_IF_ADDR_WIDTH-1:0]         o_mem_addr;
    logic                                 o_mem_req_valid;
    logic [SET_BITS_WIDTH+1:0]            o_da_w_addr;
    logic [LINE_W-1:0]                    o_da_w_data;
    logic [NUM_BLOCKS-1:0]                o_da_w_mask;
    logic                                 o_da_w_valid;
    logic [SET_BITS_WIDTH-1:0]            o_ta_w_addr;
    logic [NUM_BLOCKS*TAG_BITS_WIDTH-1:0] o_ta_w_data;
    logic [NUM_BLOCKS-1:0]                o_ta_w_wmask;
    logic                                 o_ta_w_valid;
    logic [SET_BITS_WIDTH-1:0]            o_sa_w_addr;
    logic [STATUS_W-1:0]                  o_sa_w_data;
    logic [STATUS_W-1:0]                  o_sa_w_wmask;
    logic                                 o_sa_w_valid;
    logic                                 o_refill_done;
    logic [WAY_W-1:0]                     o_refill_way;

    modport master (
        input  i_miss_valid, i_miss_tag, i_miss_set, i_miss_status, i_flush,
               i_mem_data, i_mem_data_valid,
        output o_miss_ready, o_stall, o_mem_addr, o_mem_req_valid,
               o_da_w_addr, o_da_w_data, o_da_w_mask, o_da_w_valid,
               o_ta_w_addr, o_ta_w_data, o_ta_w_wmask, o_ta_w_valid,
               o_sa_w_addr, o_sa_w_data, o_sa_w_wmask, o_sa_w_valid,
               o_refill_done, o_refill_way
    );

    modport slave (
        output i_miss_valid, i_miss_tag, i_miss_set, i_miss_status, i_flush,
               i_mem_data, i_mem_data_valid,
        input  o_miss_ready, o_stall, o_mem_addr, o_mem_req_valid,
               o_da_w_addr, o_da_w_data, o_da_w_mask, o_da_w_valid,
               o_ta_w_addr, o_ta_w_data, o_ta_w_wmask, o_ta_w_valid,
               o_sa_w_addr, o_sa_w_data, o_sa_w_wmask, o_sa_w_valid,
               o_refill_done, o_refill_way
    );
endinterface

// File: rtl/icache_refill_controller.sv
// icache_refill_controller
// Miss-handling sequencer for the instruction cache. On a miss it picks a
// victim way from the set's valid/used bits, requests the line from memory,
// writes the four fill beats into the data array, then commits the tag and
// the updated status word. On a flush request it clears all status words.
// The pipeline is stalled for the whole of either operation.
// Ports:
//   clk  - clock
//   srst - synchronous active-high reset, aborts any operation in progress
//   bus  - icache_refill_if master modport (miss/flush/fill in, arrays out)
module icache_refill_controller #(
    parameter int TAG_BITS_WIDTH    = 8,
    parameter int SET_BITS_WIDTH    = 4,
    parameter int NUM_BLOCKS        = 4,
    parameter int WORD_WIDTH        = 20,
    parameter int MEM_IF_DATA_WIDTH = 128,
    parameter int MEM_IF_ADDR_WIDTH = 16
) (
    input logic             clk,
    input logic             srst,
    icache_refill_if.master bus
);
    localparam int WAY_W    = $clog2(NUM_BLOCKS);
    localparam int STATUS_W = 2 * NUM_BLOCKS;
    localparam int LINE_W   = 4 * WORD_WIDTH;
    localparam int OFFSET_W = MEM_IF_ADDR_WIDTH - TAG_BITS_WIDTH - SET_BITS_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FILL,
        COMMIT,
        DONE,
        FLUSH
    } state_t;

    state_t                    state;
    logic [TAG_BITS_WIDTH-1:0] tag_q;
    logic [SET_BITS_WIDTH-1:0] set_q;
    logic [WAY_W-1:0]          way_q;
    logic [STATUS_W-1:0]       status_q;
    // Beat index during a fill (low two bits), set index during a flush.
    logic [SET_BITS_WIDTH-1:0] count_q;

    logic [WAY_W-1:0]          victim;
    logic [STATUS_W-1:0]       new_status;
    logic [NUM_BLOCKS-1:0]     way_onehot;
    // Only the low four words of a memory beat carry instructions.
    logic                      unused_mem_bits;

    // Prefer an empty way, then one not recently used, otherwise way 0.
    function automatic logic [WAY_W-1:0] pick_victim(input logic [STATUS_W-1:0] s);
        logic             found;
        logic [WAY_W-1:0] way;
        found = 1'b0;
        way   = '0;
        for (int w = 0; w < NUM_BLOCKS; w++) begin
            if (!found && !s[2*w]) begin
                way   = WAY_W'(w);
                found = 1'b1;
            end
        end
        for (int w = 0; w < NUM_BLOCKS; w++) begin
            if (!found && !s[2*w+1]) begin
                way   = WAY_W'(w);
                found = 1'b1;
            end
        end
        return way;
    endfunction

    // Mark the victim valid and used; once every way is marked used, age the
    // other ways so the pseudo-LRU keeps distinguishing them.
    function automatic logic [STATUS_W-1:0] update_status(input logic [STATUS_W-1:0] s,
                                                          input logic [WAY_W-1:0]    way);
        logic [STATUS_W-1:0] n;
        logic                all_used;
        n                   = s;
        n[2*int'(way)]      = 1'b1;
        n[2*int'(way)+1]    = 1'b1;
        all_used            = 1'b1;
        for (int w = 0; w < NUM_BLOCKS; w++) begin
            all_used = all_used & n[2*w+1];
        end
        if (all_used) begin
            for (int w = 0; w < NUM_BLOCKS; w++) begin
                if (WAY_W'(w) != way) begin
                    n[2*w+1] = 1'b0;
                end
            end
        end
        return n;
    endfunction

    assign victim          = pick_victim(bus.i_miss_status);
    assign new_status      = update_status(bus.i_miss_status, victim);
    assign way_onehot      = NUM_BLOCKS'(1) << way_q;
    assign unused_mem_bits = ^bus.i_mem_data[MEM_IF_DATA_WIDTH-1:LINE_W];

    // Sequencer: every output is a register; strobes default low each cycle
    // and are raised only in the cycle their state calls for.
    always_ff @(posedge clk) begin
        if (srst) begin
            state               <= IDLE;
            tag_q               <= '0;
            set_q               <= '0;
            way_q               <= '0;
            status_q            <= '0;
            count_q             <= '0;
            bus.o_miss_ready    <= 1'b0;
            bus.o_stall         <= 1'b0;
            bus.o_mem_addr      <= '0;
            bus.o_mem_req_valid <= 1'b0;
            bus.o_da_w_addr     <= '0;
            bus.o_da_w_data     <= '0;
            bus.o_da_w_mask     <= '0;
            bus.o_da_w_valid    <= 1'b0;
            bus.o_ta_w_addr     <= '0;
            bus.o_ta_w_data     <= '0;
            bus.o_ta_w_wmask    <= '0;
            bus.o_ta_w_valid    <= 1'b0;
            bus.o_sa_w_addr     <= '0;
            bus.o_sa_w_data     <= '0;
            bus.o_sa_w_wmask    <= '0;
            bus.o_sa_w_valid    <= 1'b0;
            bus.o_refill_done   <= 1'b0;
            bus.o_refill_way    <= '0;
        end else begin
            bus.o_mem_req_valid <= 1'b0;
            bus.o_da_w_valid    <= 1'b0;
            bus.o_ta_w_valid    <= 1'b0;
            bus.o_sa_w_valid    <= 1'b0;
            bus.o_refill_done   <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.i_flush) begin
                        // First clear is issued on entry so the sixteen
                        // writes fill the sixteen FLUSH cycles exactly.
                        state            <= FLUSH;
                        count_q          <= '0;
                        bus.o_sa_w_valid <= 1'b1;
                        bus.o_sa_w_addr  <= '0;
                        bus.o_sa_w_data  <= '0;
                        bus.o_sa_w_wmask <= '1;
                        bus.o_miss_ready <= 1'b0;
                        bus.o_stall      <= 1'b1;
                    end else if (bus.i_miss_valid) begin
                        state               <= REQ;
                        tag_q               <= bus.i_miss_tag;
                        set_q               <= bus.i_miss_set;
                        way_q               <= victim;
                        status_q            <= new_status;
                        bus.o_mem_req_valid <= 1'b1;
                        bus.o_mem_addr      <= {bus.i_miss_tag, bus.i_miss_set, {OFFSET_W{1'b0}}};
                        bus.o_miss_ready    <= 1'b0;
                        bus.o_stall         <= 1'b1;
                    end else begin
                        bus.o_miss_ready <= 1'b1;
                        bus.o_stall      <= 1'b0;
                    end
                end
                REQ: begin
                    state   <= FILL;
                    count_q <= '0;
                end
                FILL: begin
                    if (bus.i_mem_data_valid) begin
                        bus.o_da_w_valid <= 1'b1;
                        bus.o_da_w_addr  <= {set_q, count_q[1:0]};
                        bus.o_da_w_data  <= bus.i_mem_data[LINE_W-1:0];
                        bus.o_da_w_mask  <= way_onehot;
                        count_q          <= count_q + 1'b1;
                        if (count_q[1:0] == 2'd3) begin
                            // Tag and status commit alongside the last data write.
                            state            <= COMMIT;
                            bus.o_ta_w_valid <= 1'b1;
                            bus.o_ta_w_addr  <= set_q;
                            bus.o_ta_w_data  <= {NUM_BLOCKS{tag_q}};
                            bus.o_ta_w_wmask <= way_onehot;
                            bus.o_sa_w_valid <= 1'b1;
                            bus.o_sa_w_addr  <= set_q;
                            bus.o_sa_w_data  <= status_q;
                            bus.o_sa_w_wmask <= '1;
                        end
                    end
                end
                COMMIT: begin
                    state             <= DONE;
                    bus.o_refill_done <= 1'b1;
                    bus.o_refill_way  <= way_q;
                end
                DONE: begin
                    state            <= IDLE;
                    bus.o_miss_ready <= 1'b1;
                    bus.o_stall      <= 1'b0;
                end
                FLUSH: begin
                    if (count_q == '1) begin
                        state            <= IDLE;
                        bus.o_miss_ready <= 1'b1;
                        bus.o_stall      <= 1'b0;
                    end else begin
                        count_q          <= count_q + 1'b1;
                        bus.o_sa_w_valid <= 1'b1;
                        bus.o_sa_w_addr  <= count_q + 1'b1;
                        bus.o_sa_w_data  <= '0;
                        bus.o_sa_w_wmask <= '1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_refill_controller.sv
// tb_icache_refill_controller
// Scoreboard bench for the refill controller: each stimulus task pushes the
// writes and pulses it expects (with the cycle they must appear in) and a
// negedge monitor pops and compares them as the controller produces them.
module tb_icache_refill_controller;
    typedef struct {
        logic [15:0] addr;
        logic [79:0] data;
        logic [31:0] mask;
        int          cyc;
    } exp_t;

    logic clk;
    logic srst;
    int   cycle;
    int   checks;
    int   errors;

    exp_t exp_req[$];
    exp_t exp_da[$];
    exp_t exp_ta[$];
    exp_t exp_sa[$];
    exp_t exp_done[$];

    icache_refill_if bus ();

    icache_refill_controller dut (
        .clk  (clk),
        .srst (srst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Every comparison in the bench funnels through here.
    task automatic checkOutput(input string tag, input logic [79:0] actual,
                               input logic [79:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h cycle=%0d", tag, actual, expected, cycle);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] a, input logic [79:0] d,
                                input logic [31:0] m, input int c);
        exp_t e;
        e.addr = a;
        e.data = d;
        e.mask = m;
        e.cyc  = c;
        return e;
    endfunction

    // Reference replacement policy, written from the valid/used rules.
    function automatic void model_refill(input logic [7:0] st, output logic [1:0] way,
                                         output logic [7:0] ns);
        int w;
        w = -1;
        for (int i = 0; i < 4; i++) if (w < 0 && st[2*i] == 1'b0) w = i;
        for (int i = 0; i < 4; i++) if (w < 0 && st[2*i+1] == 1'b0) w = i;
        if (w < 0) w = 0;
        ns = st | (8'b11 << (2*w));
        if ((ns & 8'hAA) == 8'hAA) ns = (ns & 8'h55) | (8'b10 << (2*w));
        way = w[1:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: any strobe must match the head of its queue, in the right cycle.
    always @(negedge clk) begin
        exp_t e;
        if (bus.o_mem_req_valid || bus.o_da_w_valid || bus.o_ta_w_valid ||
            bus.o_sa_w_valid || bus.o_refill_done) begin
            checkOutput("stall_in_op", bus.o_stall, 1'b1);
            checkOutput("ready_in_op", bus.o_miss_ready, 1'b0);
        end
        if (bus.o_mem_req_valid) begin
            if (exp_req.size() == 0) checkOutput("req_unexpected", bus.o_mem_req_valid, 1'b0);
            else begin
                e = exp_req.pop_front();
                checkOutput("req_addr", bus.o_mem_addr, e.addr);
                checkOutput("req_cycle", cycle, e.cyc);
            end
        end
        if (bus.o_da_w_valid) begin
            if (exp_da.size() == 0) checkOutput("da_unexpected", bus.o_da_w_valid, 1'b0);
            else begin
                e = exp_da.pop_front();
                checkOutput("da_addr", bus.o_da_w_addr, e.addr);
                checkOutput("da_data", bus.o_da_w_data, e.data);
                checkOutput("da_mask", bus.o_da_w_mask, e.mask);
                checkOutput("da_cycle", cycle, e.cyc);
            end
        end
        if (bus.o_ta_w_valid) begin
            if (exp_ta.size() == 0) checkOutput("ta_unexpected", bus.o_ta_w_valid, 1'b0);
            else begin
                e = exp_ta.pop_front();
                checkOutput("ta_addr", bus.o_ta_w_addr, e.addr);
                checkOutput("ta_data", bus.o_ta_w_data, e.data);
                checkOutput("ta_wmask", bus.o_ta_w_wmask, e.mask);
                checkOutput("ta_cycle", cycle, e.cyc);
            end
        end
        if (bus.o_sa_w_valid) begin
            if (exp_sa.size() == 0) checkOutput("sa_unexpected", bus.o_sa_w_valid, 1'b0);
            else begin
                e = exp_sa.pop_front();
                checkOutput("sa_addr", bus.o_sa_w_addr, e.addr);
                checkOutput("sa_data", bus.o_sa_w_data, e.data);
                checkOutput("sa_wmask", bus.o_sa_w_wmask, e.mask);
                checkOutput("sa_cycle", cycle, e.cyc);
            end
        end
        if (bus.o_refill_done) begin
            if (exp_done.size() == 0) checkOutput("done_unexpected", bus.o_refill_done, 1'b0);
            else begin
                e = exp_done.pop_front();
                checkOutput("done_way", bus.o_refill_way, e.addr);
                checkOutput("done_cycle", cycle, e.cyc);
            end
        end
    end

    // One miss: optional simultaneous flush, optional reset after beat 2,
    // and a configurable number of idle cycles between beats.
    task automatic applyStimulus(input logic [7:0] tag, input logic [3:0] set,
                                 input logic [7:0] status, input int gap,
                                 input bit with_flush, input bit reset_after_beat2);
        logic [1:0]  way;
        logic [7:0]  ns;
        logic [79:0] d;
        int          start;
        int          last;
        int          n;
        int          nbeats;

        model_refill(status, way, ns);
        nbeats = reset_after_beat2 ? 3 : 4;
        last   = 0;

        n = 0;
        @(negedge clk);
        while (!bus.o_miss_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("ready_before_miss", bus.o_miss_ready, 1'b1);

        tick();
        start             = cycle;
        bus.i_miss_valid  = 1'b1;
        bus.i_miss_tag    = tag;
        bus.i_miss_set    = set;
        bus.i_miss_status = status;
        bus.i_flush       = with_flush;

        if (with_flush) begin
            for (int i = 0; i < 16; i++) exp_sa.push_back(mk(16'(i), 80'h0, 32'hFF, start + 1 + i));
            tick();
            bus.i_flush = 1'b0;
            for (int i = 1; i <= 16; i++) begin
                @(negedge clk);
                checkOutput("flush_ready_low", bus.o_miss_ready, 1'b0);
                bus.i_flush = (i == 4);
            end
            @(negedge clk);
            checkOutput("flush_ready_back", bus.o_miss_ready, 1'b1);
            start = start + 17;
        end
        tick();
        bus.i_miss_valid = 1'b0;
        bus.i_miss_tag   = 8'hFF;
        exp_req.push_back(mk({tag, set, 4'h0}, 80'h0, 32'h0, start + 1));

        tick();
        for (int b = 0; b < nbeats; b++) begin
            if (b > 0) begin
                bus.i_mem_data_valid = 1'b0;
                repeat (gap) tick();
            end
            bus.i_mem_data       = {$urandom(), $urandom(), $urandom(), $urandom()};
            d                    = bus.i_mem_data[79:0];
            bus.i_mem_data_valid = 1'b1;
            exp_da.push_back(mk({10'h0, set, 2'(b)}, d, 32'(4'b0001 << way), cycle + 1));
            last = cycle;
            tick();
        end
        bus.i_mem_data_valid = 1'b0;

        if (reset_after_beat2) begin
            srst = 1'b1;
            tick();
            srst                 = 1'b0;
            bus.i_mem_data_valid = 1'b1;
            @(negedge clk);
            checkOutput("abort_strobes", {bus.o_mem_req_valid, bus.o_da_w_valid, bus.o_ta_w_valid,
                                          bus.o_sa_w_valid, bus.o_refill_done}, 5'b0);
            checkOutput("abort_ready_low", bus.o_miss_ready, 1'b0);
            checkOutput("abort_stall_low", bus.o_stall, 1'b0);
            tick();
            bus.i_mem_data_valid = 1'b0;
            @(negedge clk);
            checkOutput("abort_ready_back", bus.o_miss_ready, 1'b1);
        end else begin
            exp_ta.push_back(mk({12'h0, set}, {4{tag}}, 32'(4'b0001 << way), last + 1));
            exp_sa.push_back(mk({12'h0, set}, {72'h0, ns}, 32'hFF, last + 1));
            exp_done.push_back(mk({14'h0, way}, 80'h0, 32'h0, last + 2));
            tick();
            @(negedge clk);
            checkOutput("ready_during_done", bus.o_miss_ready, 1'b0);
            tick();
            bus.i_mem_data_valid = 1'b1;
            @(negedge clk);
            checkOutput("ready_after_done", bus.o_miss_ready, 1'b1);
            tick();
            bus.i_mem_data_valid = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cycle);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks               = 0;
        errors               = 0;
        cycle                = 0;
        srst                 = 1'b1;
        bus.i_miss_valid     = 1'b0;
        bus.i_miss_tag       = '0;
        bus.i_miss_set       = '0;
        bus.i_miss_status    = '0;
        bus.i_flush          = 1'b0;
        bus.i_mem_data       = '0;
        bus.i_mem_data_valid = 1'b0;

        repeat (3) tick();
        @(negedge clk);
        checkOutput("reset_ready", bus.o_miss_ready, 1'b0);
        checkOutput("reset_stall", bus.o_stall, 1'b0);
        checkOutput("reset_strobes", {bus.o_mem_req_valid, bus.o_da_w_valid, bus.o_ta_w_valid,
                                      bus.o_sa_w_valid, bus.o_refill_done}, 5'b0);
        checkOutput("reset_mem_addr", bus.o_mem_addr, 16'h0);
        checkOutput("reset_refill_way", bus.o_refill_way, 2'h0);
        tick();
        srst = 1'b0;
        @(negedge clk);
        checkOutput("ready_first_cycle", bus.o_miss_ready, 1'b0);
        @(negedge clk);
        checkOutput("ready_after_reset", bus.o_miss_ready, 1'b1);

        applyStimulus(8'h3A, 4'h5, 8'h00, 0, 1'b0, 1'b0);
        applyStimulus(8'h9C, 4'h2, 8'hBF, 0, 1'b0, 1'b0);
        applyStimulus(8'hC4, 4'hB, 8'h0F, 2, 1'b0, 1'b0);
        applyStimulus(8'h11, 4'hF, 8'h7F, 0, 1'b1, 1'b0);
        applyStimulus(8'h5E, 4'h3, 8'h3C, 0, 1'b0, 1'b1);
        applyStimulus(8'h77, 4'h9, 8'h55, 1, 1'b0, 1'b0);

        repeat (10) tick();
        checkOutput("sb_req_left", exp_req.size(), 0);
        checkOutput("sb_da_left", exp_da.size(), 0);
        checkOutput("sb_ta_left", exp_ta.size(), 0);
        checkOutput("sb_sa_left", exp_sa.size(), 0);
        checkOutput("sb_done_left", exp_done.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
